// File: rtl/gl_tri_assembler.sv
// Triangle assembler: builds list/strip triangles from a vertex stream, queues them in a
// DEPTH-entry FIFO and issues one triangle at a time, waiting for raster_ready before the next.
module gl_tri_assembler #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          prim_mode,
  input  logic          strip_restart,
  input  logic          vtx_valid,
  input  logic [95:0]   vtx_data,
  output logic          vtx_ready,
  output logic          fifo_ready,
  output logic [95:0]   fifo_in1,
  output logic [95:0]   fifo_in2,
  output logic [95:0]   fifo_in3,
  input  logic          raster_ready,
  output logic [AW:0]   tri_count
);

  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   CNT_DEPTH = (AW+1)'(DEPTH);

  logic [287:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          busy;

  logic [1:0]    vcnt;
  logic [95:0]   va;
  logic [95:0]   vb;
  logic          parity;
  logic          last_mode;

  logic          full;
  logic          empty;
  logic          accept;
  logic          restart;
  logic [1:0]    eff_vcnt;
  logic          eff_parity;
  logic          push;
  logic          pop;
  logic [287:0]  push_data;

  assign full      = (count == CNT_DEPTH);
  assign empty     = (count == '0);
  assign vtx_ready = !full;
  assign tri_count = count;

  // A restart (explicit or mode change) takes effect in the same cycle, so a vertex
  // accepted alongside it already sees an empty primitive.
  always_comb begin
    accept     = vtx_valid && !full;
    restart    = strip_restart || (prim_mode != last_mode);
    eff_vcnt   = restart ? 2'd0 : vcnt;
    eff_parity = restart ? 1'b0 : parity;
    push       = accept && (eff_vcnt == 2'd2);
    pop        = !empty && !busy;
    push_data  = {va, vb, vtx_data};
    if (prim_mode && eff_parity) begin
      push_data = {vb, va, vtx_data};
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      busy       <= 1'b0;
      fifo_ready <= 1'b0;
      fifo_in1   <= '0;
      fifo_in2   <= '0;
      fifo_in3   <= '0;
    end else begin
      fifo_ready <= pop;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr                         <= rd_ptr + PTR_ONE;
        {fifo_in1, fifo_in2, fifo_in3} <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      // Issue wins over a completion pulse seen while idle; that pulse is stray.
      if (pop) begin
        busy <= 1'b1;
      end else if (raster_ready) begin
        busy <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vcnt      <= 2'd0;
      va        <= '0;
      vb        <= '0;
      parity    <= 1'b0;
      last_mode <= 1'b0;
    end else if (accept) begin
      last_mode <= prim_mode;
      case (eff_vcnt)
        2'd0: begin
          va     <= vtx_data;
          vcnt   <= 2'd1;
          parity <= eff_parity;
        end
        2'd1: begin
          vb     <= vtx_data;
          vcnt   <= 2'd2;
          parity <= eff_parity;
        end
        default: begin
          if (prim_mode) begin
            // Strip: slide the window and flip winding for the next triangle.
            va     <= vb;
            vb     <= vtx_data;
            parity <= !eff_parity;
            vcnt   <= 2'd2;
          end else begin
            vcnt   <= 2'd0;
            parity <= 1'b0;
          end
        end
      endcase
    end else if (restart) begin
      vcnt   <= 2'd0;
      parity <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gl_tri_assembler.sv
// Self-checking bench for gl_tri_assembler: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_gl_tri_assembler;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          prim_mode;
  logic          strip_restart;
  logic          vtx_valid;
  logic [95:0]   vtx_data;
  logic          vtx_ready;
  logic          fifo_ready;
  logic [95:0]   fifo_in1;
  logic [95:0]   fifo_in2;
  logic [95:0]   fifo_in3;
  logic          raster_ready;
  logic [AW:0]   tri_count;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  logic [287:0] m_q[$];
  logic [95:0]  m_prim[$];
  logic         m_prev_mode;
  logic         m_busy;
  logic         m_fr;
  logic [287:0] m_last;

  gl_tri_assembler #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .prim_mode(prim_mode), .strip_restart(strip_restart),
    .vtx_valid(vtx_valid), .vtx_data(vtx_data), .vtx_ready(vtx_ready),
    .fifo_ready(fifo_ready), .fifo_in1(fifo_in1), .fifo_in2(fifo_in2), .fifo_in3(fifo_in3),
    .raster_ready(raster_ready), .tri_count(tri_count)
  );

  always #5 clk = ~clk;

  function automatic logic [95:0] rnd_vtx();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  // Drive one cycle of inputs, advance the model across the edge, return the DUT handshake.
  task automatic step(input logic v, input logic [95:0] d, input logic m, input logic sr,
                      input logic rr, input logic rst, output logic acc);
    logic         issue;
    logic         macc;
    int           n;
    @(negedge clk);
    vtx_valid = v; vtx_data = d; prim_mode = m; strip_restart = sr;
    raster_ready = rr; reset = rst;
    #1;
    acc = v && vtx_ready;
    @(posedge clk);
    if (rst) begin
      m_q.delete(); m_prim.delete();
      m_prev_mode = 1'b0; m_busy = 1'b0; m_fr = 1'b0; m_last = '0;
    end else begin
      issue = (m_q.size() != 0) && !m_busy;
      macc  = v && (m_q.size() < DEPTH);
      if (issue) m_last = m_q.pop_front();
      if (sr || (m != m_prev_mode)) m_prim.delete();
      if (macc) begin
        m_prim.push_back(d);
        m_prev_mode = m;
        n = m_prim.size();
        if (!m && n == 3) begin
          m_q.push_back({m_prim[0], m_prim[1], m_prim[2]});
          m_prim.delete();
        end else if (m && n >= 3) begin
          if (((n - 3) % 2) == 0) m_q.push_back({m_prim[n-3], m_prim[n-2], m_prim[n-1]});
          else                    m_q.push_back({m_prim[n-2], m_prim[n-3], m_prim[n-1]});
        end
      end
      if (issue) m_busy = 1'b1;
      else if (rr) m_busy = 1'b0;
      m_fr = issue;
    end
    #1;
  endtask

  task automatic test_reset();
    logic acc;
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, acc);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, acc);
    n_checks++; if (fifo_ready !== 1'b0) begin n_errors++; $display("FAIL reset_fifo_ready got %b want 0", fifo_ready); end
    n_checks++; if (tri_count !== 3'd0) begin n_errors++; $display("FAIL reset_tri_count got %0d want 0", tri_count); end
    n_checks++; if (vtx_ready !== 1'b1) begin n_errors++; $display("FAIL reset_vtx_ready got %b want 1", vtx_ready); end
    n_checks++; if ({fifo_in1, fifo_in2, fifo_in3} !== 288'd0) begin n_errors++; $display("FAIL reset_fifo_in got %h want 0", {fifo_in1, fifo_in2, fifo_in3}); end
  endtask

  task automatic test_list_single();
    logic acc;
    logic [95:0] a, b, c;
    int pulses;
    a = rnd_vtx(); b = rnd_vtx(); c = rnd_vtx();
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, acc);
    step(1'b1, a, 1'b0, 1'b0, 1'b0, 1'b0, acc);
    step(1'b1, b, 1'b0, 1'b0, 1'b0, 1'b0, acc);
    step(1'b1, c, 1'b0, 1'b0, 1'b0, 1'b0, acc);
    n_checks++; if (fifo_ready !== 1'b0 || tri_count !== 3'd1) begin n_errors++; $display("FAIL list_push fifo_ready=%b tri_count=%0d want 0/1", fifo_ready, tri_count); end
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, acc);
    n_checks++; if (fifo_ready !== 1'b1) begin n_errors++; $display("FAIL list_issue got %b want 1", fifo_ready); end
    n_checks++; if ({fifo_in1, fifo_in2, fifo_in3} !== {a, b, c}) begin n_errors++; $display("FAIL list_tri got %h want %h", {fifo_in1, fifo_in2, fifo_in3}, {a, b, c}); end
    n_checks++; if (tri_count !== 3'd0) begin n_errors++; $display("FAIL list_count got %0d want 0", tri_count); end
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, acc);
      if (fifo_ready) pulses++;
    end
    n_checks++; if (pulses !== 0) begin n_errors++; $display("FAIL list_hold pulses got %0d want 0", pulses); end
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, acc);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, acc);
    n_checks++; if (fifo_ready !== 1'b0 || {fifo_in1, fifo_in2, fifo_in3} !== {a, b, c}) begin n_errors++; $display("FAIL list_after_done fifo_ready=%b in=%h want 0/%h", fifo_ready, {fifo_in1, fifo_in2, fifo_in3}, {a, b, c}); end
  endtask

  task automatic test_strip();
    logic acc, pend;
    logic [95:0] v[5];
    logic [287:0] issued[$];
    logic [287:0] exp_t[3];
    for (int i = 0; i < 5; i++) v[i] = rnd_vtx();
    exp_t[0] = {v[0], v[1], v[2]};
    exp_t[1] = {v[2], v[1], v[3]};
    exp_t[2] = {v[2], v[3], v[4]};
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, acc);
    pend = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step(i < 5, (i < 5) ? v[i] : 96'd0, 1'b1, 1'b0, pend, 1'b0, acc);
      if (fifo_ready) issued.push_back({fifo_in1, fifo_in2, fifo_in3});
      pend = fifo_ready;
    end
    n_checks++; if (issued.size() !== 3) begin n_errors++; $display("FAIL strip_count got %0d want 3", issued.size()); end
    for (int i = 0; i < 3; i++) begin
      if (i < issued.size()) begin
        n_checks++;
        if (issued[i] !== exp_t[i]) begin n_errors++; $display("FAIL strip_tri%0d got %h want %h", i, issued[i], exp_t[i]); end
      end
    end
  endtask

  task automatic test_full_stall();
    logic acc;
    logic [95:0] v[16];
    int k, pulses;
    for (int i = 0; i < 16; i++) v[i] = rnd_vtx();
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, acc);
    k = 0; pulses = 0;
    for (int i = 0; i < 30; i++) begin
      step(k < 16, v[(k < 16) ? k : 15], 1'b0, 1'b0, 1'b0, 1'b0, acc);
      if (acc) k++;
      if (fifo_ready) pulses++;
    end
    n_checks++; if (pulses !== 1) begin n_errors++; $display("FAIL full_pulses got %0d want 1", pulses); end
    n_checks++; if (tri_count !== 3'd4) begin n_errors++; $display("FAIL full_count got %0d want 4", tri_count); end
    n_checks++; if (vtx_ready !== 1'b0 || k !== 15) begin n_errors++; $display("FAIL full_stall vtx_ready=%b accepted=%0d want 0/15", vtx_ready, k); end
    step(1'b1, v[15], 1'b0, 1'b0, 1'b1, 1'b0, acc);
    n_checks++; if (acc !== 1'b0 || fifo_ready !== 1'b0) begin n_errors++; $display("FAIL full_done acc=%b fifo_ready=%b want 0/0", acc, fifo_ready); end
    step(1'b1, v[15], 1'b0, 1'b0, 1'b0, 1'b0, acc);
    n_checks++; if (fifo_ready !== 1'b1 || tri_count !== 3'd3) begin n_errors++; $display("FAIL full_reissue fifo_ready=%b tri_count=%0d want 1/3", fifo_ready, tri_count); end
    n_checks++; if ({fifo_in1, fifo_in2, fifo_in3} !== {v[3], v[4], v[5]}) begin n_errors++; $display("FAIL full_tri2 got %h want %h", {fifo_in1, fifo_in2, fifo_in3}, {v[3], v[4], v[5]}); end
    step(1'b1, v[15], 1'b0, 1'b0, 1'b0, 1'b0, acc);
    n_checks++; if (acc !== 1'b1 || tri_count !== 3'd3) begin n_errors++; $display("FAIL full_v16 acc=%b tri_count=%0d want 1/3", acc, tri_count); end
  endtask

  task automatic test_restart();
    logic acc, pend;
    logic [95:0] v[5];
    logic [287:0] issued[$];
    for (int i = 0; i < 5; i++) v[i] = rnd_vtx();
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, acc);
    pend = 1'b0;
    for (int i = 0; i < 25; i++) begin
      step(i < 5, (i < 5) ? v[i] : 96'd0, 1'b1, (i == 2), pend, 1'b0, acc);
      if (fifo_ready) issued.push_back({fifo_in1, fifo_in2, fifo_in3});
      pend = fifo_ready;
    end
    n_checks++; if (issued.size() !== 1) begin n_errors++; $display("FAIL restart_count got %0d want 1", issued.size()); end
    if (issued.size() > 0) begin
      n_checks++;
      if (issued[0] !== {v[2], v[3], v[4]}) begin n_errors++; $display("FAIL restart_tri got %h want %h", issued[0], {v[2], v[3], v[4]}); end
    end
  endtask

  task automatic test_reset_mid();
    logic acc;
    int pulses;
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, acc);
    for (int i = 0; i < 9; i++) step(1'b1, rnd_vtx(), 1'b0, 1'b0, 1'b0, 1'b0, acc);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, acc);
    n_checks++; if (tri_count !== 3'd2) begin n_errors++; $display("FAIL rstmid_pre got %0d want 2", tri_count); end
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, acc);
    n_checks++; if (fifo_ready !== 1'b0 || tri_count !== 3'd0 || vtx_ready !== 1'b1) begin n_errors++; $display("FAIL rstmid_post fifo_ready=%b tri_count=%0d vtx_ready=%b want 0/0/1", fifo_ready, tri_count, vtx_ready); end
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, acc);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, acc);
      if (fifo_ready) pulses++;
    end
    n_checks++; if (pulses !== 0 || tri_count !== 3'd0) begin n_errors++; $display("FAIL rstmid_rr pulses=%0d tri_count=%0d want 0/0", pulses, tri_count); end
  endtask

  task automatic test_stray_rr();
    logic acc;
    logic [95:0] a, b, c;
    int pulses;
    a = rnd_vtx(); b = rnd_vtx(); c = rnd_vtx();
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, acc);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, acc);
    n_checks++; if (fifo_ready !== 1'b0 || tri_count !== 3'd0) begin n_errors++; $display("FAIL stray_idle fifo_ready=%b tri_count=%0d want 0/0", fifo_ready, tri_count); end
    step(1'b1, a, 1'b0, 1'b0, 1'b0, 1'b0, acc);
    step(1'b1, b, 1'b0, 1'b0, 1'b1, 1'b0, acc);
    step(1'b1, c, 1'b0, 1'b0, 1'b0, 1'b0, acc);
    n_checks++; if (tri_count !== 3'd1) begin n_errors++; $display("FAIL stray_asm got %0d want 1", tri_count); end
    // stray pulse in the very edge that issues: must be ignored, busy must stay set
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, acc);
    n_checks++; if (fifo_ready !== 1'b1 || {fifo_in1, fifo_in2, fifo_in3} !== {a, b, c}) begin n_errors++; $display("FAIL stray_issue fifo_ready=%b in=%h want 1/%h", fifo_ready, {fifo_in1, fifo_in2, fifo_in3}, {a, b, c}); end
    for (int i = 0; i < 3; i++) step(1'b1, rnd_vtx(), 1'b0, 1'b0, 1'b0, 1'b0, acc);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, acc);
      if (fifo_ready) pulses++;
    end
    n_checks++; if (pulses !== 0 || tri_count !== 3'd1) begin n_errors++; $display("FAIL stray_busy pulses=%0d tri_count=%0d want 0/1", pulses, tri_count); end
  endtask

  task automatic test_random();
    logic acc, v, sr, rr, rst, cur_mode;
    int errs_here;
    errs_here = 0;
    cur_mode = 1'b0;
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, acc);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0) cur_mode = !cur_mode;
      v   = ($urandom_range(0, 9) < 7);
      sr  = ($urandom_range(0, 19) == 0);
      rr  = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 249) == 0);
      step(v, rnd_vtx(), cur_mode, sr, rr, rst, acc);
      n_checks++;
      if (fifo_ready !== m_fr || tri_count !== 3'(m_q.size()) || vtx_ready !== (m_q.size() < DEPTH) ||
          {fifo_in1, fifo_in2, fifo_in3} !== m_last) begin
        n_errors++;
        errs_here++;
        if (errs_here <= 5)
          $display("FAIL random cyc%0d fr=%b/%b cnt=%0d/%0d rdy=%b in=%h want %h", i, fifo_ready, m_fr,
                   tri_count, m_q.size(), vtx_ready, {fifo_in1, fifo_in2, fifo_in3}, m_last);
      end
    end
  endtask

  initial begin
    reset = 1'b1; prim_mode = 1'b0; strip_restart = 1'b0; vtx_valid = 1'b0;
    vtx_data = '0; raster_ready = 1'b0;
    m_prev_mode = 1'b0; m_busy = 1'b0; m_fr = 1'b0; m_last = '0;
    test_reset();
    test_list_single();
    test_strip();
    test_full_stall();
    test_restart();
    test_reset_mid();
    test_stray_rr();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
